// File: rtl/comparator_seq.sv
// Serial magnitude comparator: one 2-bit slice walks a WIDTH-bit operand pair MSB digit first.
// Optional build macro CMP_EARLY_EXIT_EN finishes on the first differing digit.
module comparator_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [5:0]       Y
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_t;

  state_t           state;
  dec_t             dec;
  dec_t             dec_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             finish;

  function automatic logic [5:0] flags(input dec_t d);
    case (d)
      DEC_GT:  flags = 6'b011010;
      DEC_LT:  flags = 6'b010101;
      default: flags = 6'b100011;
    endcase
  endfunction

  // The first differing digit decides; later digits cannot override it.
  function automatic dec_t resolve(input dec_t d, input logic [1:0] a_dig, input logic [1:0] b_dig);
    if (d != DEC_EQ || a_dig == b_dig) resolve = d;
    else if (a_dig > b_dig)            resolve = DEC_GT;
    else                               resolve = DEC_LT;
  endfunction

  // Operands shift left each RUN cycle, so the current digit is always the top slice.
  always_comb begin
    dec_nxt = resolve(dec, a_q[WIDTH-1 -: 2], b_q[WIDTH-1 -: 2]);
`ifdef CMP_EARLY_EXIT_EN
    finish  = (idx == '0) || (dec == DEC_EQ && dec_nxt != DEC_EQ);
`else
    finish  = (idx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Y     <= 6'b000000;
      dec   <= DEC_EQ;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            idx   <= IDX_W'(N - 1);
            dec   <= DEC_EQ;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dec <= dec_nxt;
          a_q <= a_q << 2;
          b_q <= b_q << 2;
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            Y     <= flags(dec_nxt);
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Directed-vector bench for comparator_seq (WIDTH=8): table of operand pairs plus
// hand-written sequences for ignored starts, mid-run reset and back-to-back starts.
module tb_comparator_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [5:0] Y;

  int n_vec = 0;
  int n_err = 0;

  comparator_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] y;
    int         lat;
    int         lat_ee;
  } vec_t;

  localparam logic [5:0] Y_EQ = 6'b100011;
  localparam logic [5:0] Y_GT = 6'b011010;
  localparam logic [5:0] Y_LT = 6'b010101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch a compare (start sampled at E0) and wait for done, counting edges after E0.
  // A second start can be injected so that it is sampled at edge E<inj_k>.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input int inj_k,
                         output int lat, output logic [5:0] y_o);
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(posedge clk);
    #1;
    check("busy_after_e0", 32'(busy), 32'd1);
    lat = 0;
    y_o = 6'b000000;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == inj_k) begin
        start = 1'b1; A = 8'hFF; B = 8'h00;
      end else begin
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        y_o = Y;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within 20 cycles for A=%h B=%h", a, b);
    end
  endtask

  vec_t       tv[10];
  int         lat;
  int         exp_lat;
  logic [5:0] y_got;
  logic [5:0] prev_y;
  logic       seen_done;
  logic [7:0] pa[3];
  logic [7:0] pb[3];
  logic [5:0] py[3];
  int         plat[3];
  int         acc;
  int         p;

  initial begin
    tv[0] = '{8'hA5, 8'hA5, Y_EQ, 4, 4};
    tv[1] = '{8'h80, 8'h7F, Y_GT, 4, 1};
    tv[2] = '{8'h01, 8'h02, Y_LT, 4, 4};
    tv[3] = '{8'h00, 8'h00, Y_EQ, 4, 4};
    tv[4] = '{8'hFF, 8'h00, Y_GT, 4, 1};
    tv[5] = '{8'h00, 8'hFF, Y_LT, 4, 1};
    tv[6] = '{8'h3C, 8'h34, Y_GT, 4, 3};
    tv[7] = '{8'hFE, 8'hFF, Y_LT, 4, 4};
    tv[8] = '{8'h40, 8'h3F, Y_GT, 4, 1};
    tv[9] = '{8'hC7, 8'hC6, Y_GT, 4, 4};

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_y",    32'(Y),    32'd0);

    // start and rst together: reset must win
    @(negedge clk);
    start = 1'b1; A = 8'h12; B = 8'h34;
    @(posedge clk);
    #1;
    check("rst_beats_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 10; i++) begin
`ifdef CMP_EARLY_EXIT_EN
      exp_lat = tv[i].lat_ee;
`else
      exp_lat = tv[i].lat;
`endif
      run_cmp(tv[i].a, tv[i].b, 0, lat, y_got);
      check($sformatf("vec%0d_y", i),   32'(y_got), 32'(tv[i].y));
      check($sformatf("vec%0d_lat", i), 32'(lat),   32'(exp_lat));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_y_hold", i),    32'(Y),    32'(tv[i].y));
    end

    // start re-asserted at E2 while busy: ignored, operands untouched
    run_cmp(8'h10, 8'h20, 2, lat, y_got);
`ifdef CMP_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 4;
`endif
    check("ignored_start_y",   32'(y_got), 32'(Y_LT));
    check("ignored_start_lat", 32'(lat),   32'(exp_lat));
    @(posedge clk);
    #1;
    check("ignored_start_not_queued", 32'(busy), 32'd0);

    // reset sampled at E2 of a running compare aborts it
    @(negedge clk);
    start = 1'b1; A = 8'h55; B = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_y",    32'(Y),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    run_cmp(8'h55, 8'hAA, 0, lat, y_got);
`ifdef CMP_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 4;
`endif
    check("post_rst_y",   32'(y_got), 32'(Y_LT));
    check("post_rst_lat", 32'(lat),   32'(exp_lat));

    // start held high: a new compare is accepted in every done cycle
    pa = '{8'h12, 8'h99, 8'hF0};
    pb = '{8'h34, 8'h99, 8'h0F};
    py = '{Y_LT, Y_EQ, Y_GT};
`ifdef CMP_EARLY_EXIT_EN
    plat = '{2, 4, 1};
`else
    plat = '{4, 4, 4};
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = pa[0]; B = pb[0];
    @(posedge clk);
    acc = 0;
    p = 0;
    prev_y = Y;
    for (int c = 1; c <= 60 && p < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        check($sformatf("cont%0d_y", p),   32'(Y),       32'(py[p]));
        check($sformatf("cont%0d_lat", p), 32'(c - acc), 32'(plat[p]));
        acc = c + 1;
        prev_y = Y;
        p++;
        if (p < 3) begin
          A = pa[p]; B = pb[p];
        end
      end else if (p > 0) begin
        check($sformatf("cont_y_stable_c%0d", c), 32'(Y), 32'(prev_y));
      end
    end
    start = 1'b0;
    if (p < 3) begin
      n_vec++;
      n_err++;
      $display("FAIL cont_timeout: only %0d of 3 done pulses seen", p);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
